// File: rtl/fb_pkg.sv
// Shared types and defaults for the frame-buffer access scheduler: pixel codes,
// FSM state encoding and the default geometry of the map RAM and display line.
package fb_pkg;

  localparam int DEF_ADDR_W     = 16;
  localparam int DEF_DATA_W     = 16;
  localparam int DEF_LINE_WORDS = 106;
  localparam int DEF_FIFO_DEPTH = 4;

  // Widths fixed by the display geometry (up to 128 words per line, up to 512 rows).
  localparam int IDX_W = 7;
  localparam int ROW_W = 9;

  typedef enum logic [1:0] {
    PIX_BLACK = 2'd0,
    PIX_RED   = 2'd1,
    PIX_GREEN = 2'd2,
    PIX_BLUE  = 2'd3
  } pixel_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fsm_state_e;

endpackage

// File: rtl/fb_write_fifo.sv
// Small synchronous FIFO buffering map-cell writes until the RAM has an idle gap.
// Full/empty come from a registered occupancy count; pointers wrap modulo DEPTH.
module fb_write_fifo
  import fb_pkg::*;
#(
  parameter int WIDTH = DEF_ADDR_W + DEF_DATA_W,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_din,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_dout  = r_mem[r_rd_ptr];

  // A full FIFO refuses the push even if the same cycle pops.
  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order or process scheduling.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  // NOTE: the storage array is deliberately not reset; validity is tracked by
  // r_count alone, which keeps the array mappable onto plain RAM/register files.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end

endmodule

// File: rtl/fb_access_scheduler.sv
// Arbitrates the single-port map RAM between the deadline-critical VGA line fetch
// (always wins) and buffered serial cell writes drained in idle gaps.
module fb_access_scheduler
  import fb_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic              logicCLK,
  input  logic              RST_N,
  input  logic              line_req,
  input  logic [ROW_W-1:0]  line_row,
  output logic              line_word_valid,
  output logic [IDX_W-1:0]  line_word_idx,
  output logic [DATA_W-1:0] line_word,
  output logic              line_done,
  output logic              line_overrun,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int             CNT_W    = $clog2(FIFO_DEPTH) + 1;
  localparam int             FIFO_W   = ADDR_W + DATA_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);

  fsm_state_e        r_state;
  fsm_state_e        w_state_nxt;
  logic [IDX_W-1:0]  r_idx;
  logic [ADDR_W-1:0] r_base;
  logic              r_rd_valid;
  logic [IDX_W-1:0]  r_rd_idx;
  logic              r_overrun;

  logic [FIFO_W-1:0] w_fifo_dout;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [CNT_W-1:0]  w_fifo_count;
  logic              w_push;
  logic              w_pop;
  logic              w_fetch_start;
  logic              w_fetch_rd;

  // Row base address; wraps silently in ADDR_W bits.
  function automatic logic [ADDR_W-1:0] f_line_base(input logic [ROW_W-1:0] row);
    return ADDR_W'(row) * ADDR_W'(LINE_WORDS);
  endfunction

  assign w_push   = wr_valid & ~w_fifo_full;
  assign wr_ready = (w_fifo_count != CNT_W'(FIFO_DEPTH));

  fb_write_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_write_fifo (
    .i_clk   (logicCLK),
    .i_rst_n (RST_N),
    .i_push  (w_push),
    .i_din   ({wr_addr, wr_data}),
    .i_pop   (w_pop),
    .o_dout  (w_fifo_dout),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  // NOTE: every signal driven here gets a default first, so no path through the
  // case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_pop         = 1'b0;
    w_fetch_start = 1'b0;
    w_fetch_rd    = 1'b0;
    mem_en        = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    unique case (r_state)
      IDLE: begin
        if (line_req) begin
          // The fetch claims the RAM from the next cycle; any queued write waits.
          w_fetch_start = 1'b1;
          w_state_nxt   = FETCH;
        end else if (!w_fifo_empty) begin
          w_pop     = 1'b1;
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = w_fifo_dout[FIFO_W-1 -: ADDR_W];
          mem_wdata = w_fifo_dout[DATA_W-1:0];
        end
      end
      FETCH: begin
        w_fetch_rd = 1'b1;
        mem_en     = 1'b1;
        mem_addr   = r_base + ADDR_W'(r_idx);
        if (r_idx == LAST_IDX) w_state_nxt = DRAIN;
      end
      DRAIN: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge logicCLK) begin
    if (!RST_N) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_base     <= '0;
      r_rd_valid <= 1'b0;
      r_rd_idx   <= '0;
      r_overrun  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_fetch_start) begin
        r_base <= f_line_base(line_row);
        r_idx  <= '0;
      end else if (w_fetch_rd) begin
        r_idx <= r_idx + IDX_W'(1);
      end
      // Read-return pipe: tags the word arriving next cycle with its index.
      r_rd_valid <= w_fetch_rd;
      if (w_fetch_rd) r_rd_idx <= r_idx;
      if (line_req && (r_state != IDLE)) r_overrun <= 1'b1;
    end
  end

  assign line_word_valid = r_rd_valid;
  assign line_word_idx   = r_rd_idx;
  assign line_word       = r_rd_valid ? mem_rdata : '0;
  assign line_done       = r_rd_valid && (r_rd_idx == LAST_IDX);
  assign line_overrun    = r_overrun;

endmodule
